// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access size encodings,
// FSM states and the alignment rule.
package dmem_pkg;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_WORD = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Byte accesses are always aligned; half needs addr[0]=0, word addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      MEM_HALF: mis = offset[0];
      MEM_WORD: mis = (offset != 2'b00);
      default:  mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte-enables and replicated write data, plus
// lane selection and sign extension of load data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  st_size,
  input  logic [1:0]  ld_size,
  input  logic [31:0] write_data,
  input  logic [31:0] mem_word,
  output logic        st_misaligned,
  output logic        ld_misaligned,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_lanes,
  output logic [31:0] load_data
);

  logic [3:0]  be_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] fmt_s;

  always_comb begin
    st_misaligned = is_misaligned(st_size, offset);
    be_s          = 4'b0000;
    wr_lanes      = 32'h0000_0000;
    case (st_size)
      MEM_BYTE: begin
        be_s     = 4'b0001 << offset;
        wr_lanes = {4{write_data[7:0]}};
      end
      MEM_HALF: begin
        be_s     = offset[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{write_data[15:0]}};
      end
      MEM_WORD: begin
        be_s     = 4'b1111;
        wr_lanes = write_data;
      end
      default: begin
        be_s     = 4'b0000;
        wr_lanes = 32'h0000_0000;
      end
    endcase
    byte_en = st_misaligned ? 4'b0000 : be_s;
  end

  // Misaligned and idle loads both read as zero.
  always_comb begin
    ld_misaligned = is_misaligned(ld_size, offset);
    byte_s        = mem_word[{offset, 3'b000} +: 8];
    half_s        = offset[1] ? mem_word[31:16] : mem_word[15:0];
    case (ld_size)
      MEM_BYTE: fmt_s = {{24{byte_s[7]}}, byte_s};
      MEM_HALF: fmt_s = {{16{half_s[15]}}, half_s};
      MEM_WORD: fmt_s = mem_word;
      default:  fmt_s = 32'h0000_0000;
    endcase
    load_data = ld_misaligned ? 32'h0000_0000 : fmt_s;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MA stage: combinational loads, edge-committed
// stores, post-reset clear sweep, sticky misalignment capture and counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      write_data,
  input  logic [1:0]       mem_write,
  input  logic [1:0]       mem_read,
  output logic [31:0]      read_data,
  output logic             ready,
  output logic             misaligned_err,
  output logic [31:0]      err_addr,
  output logic [CNT_W-1:0] load_count,
  output logic [CNT_W-1:0] store_count
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e            state_r, state_n;
  logic [AW-1:0]     clr_idx_r;
  logic [31:0]       mem_r [DEPTH_WORDS];
  logic              err_r;
  logic [31:0]       err_addr_r;
  logic [CNT_W-1:0]  load_cnt_r, store_cnt_r;

  logic [AW-1:0]     word_idx_s;
  logic [31:0]       mem_word_s, wr_lanes_s, load_data_s;
  logic [3:0]        byte_en_s;
  logic              st_mis_s, ld_mis_s, run_s, load_ok_s, store_ok_s, mis_hit_s;

  assign word_idx_s = addr[AW+1:2];
  assign mem_word_s = mem_r[word_idx_s];
  assign run_s      = (state_r == ST_RUN);
  assign load_ok_s  = run_s && (mem_read != MEM_NONE) && !ld_mis_s;
  assign store_ok_s = run_s && (mem_write != MEM_NONE) && !st_mis_s;
  assign mis_hit_s  = run_s && (ld_mis_s || st_mis_s);

  dmem_lane_align u_align (
    .offset        (addr[1:0]),
    .st_size       (mem_write),
    .ld_size       (mem_read),
    .write_data    (write_data),
    .mem_word      (mem_word_s),
    .st_misaligned (st_mis_s),
    .ld_misaligned (ld_mis_s),
    .byte_en       (byte_en_s),
    .wr_lanes      (wr_lanes_s),
    .load_data     (load_data_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_CLEAR;
      clr_idx_r <= {AW{1'b0}};
    end else begin
      state_r <= state_n;
      if (state_r == ST_CLEAR) begin
        clr_idx_r <= clr_idx_r + 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_CLEAR: state_n = (clr_idx_r == LAST_IDX) ? ST_RUN : ST_CLEAR;
      ST_RUN:   state_n = ST_RUN;
      default:  state_n = ST_CLEAR;
    endcase
  end

  // The array has no reset of its own; the clear sweep zeroes it word by word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_r == ST_CLEAR) begin
        mem_r[clr_idx_r] <= 32'h0000_0000;
      end else if (store_ok_s) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en_s[b]) begin
            mem_r[word_idx_s][8*b +: 8] <= wr_lanes_s[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_r       <= 1'b0;
      err_addr_r  <= 32'h0000_0000;
      load_cnt_r  <= {CNT_W{1'b0}};
      store_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (mis_hit_s) begin
        err_r <= 1'b1;
        if (!err_r) begin
          err_addr_r <= addr;
        end
      end
      if (load_ok_s && (load_cnt_r != CNT_MAX)) begin
        load_cnt_r <= load_cnt_r + 1'b1;
      end
      if (store_ok_s && (store_cnt_r != CNT_MAX)) begin
        store_cnt_r <= store_cnt_r + 1'b1;
      end
    end
  end

  assign ready          = run_s;
  assign read_data      = run_s ? load_data_s : 32'h0000_0000;
  assign misaligned_err = err_r;
  assign err_addr       = err_addr_r;
  assign load_count     = load_cnt_r;
  assign store_count    = store_cnt_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and random checks of dmem_responder against a byte-addressed
// reference memory; a CNT_W=4 twin shares the stimulus to exercise saturation.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'h0, write_data = 32'h0;
  logic [1:0]  mem_write = 2'b00, mem_read = 2'b00;

  logic [31:0] read_data, err_addr;
  logic        ready, misaligned_err;
  logic [15:0] load_count, store_count;

  logic [31:0] rd4, ea4;
  logic        rdy4, err4;
  logic [3:0]  lc4, sc4;

  int total = 0;
  int bad = 0;

  logic [7:0]  ref_mem [BYTES];
  bit          ref_err;
  logic [31:0] ref_err_addr;
  int          ref_loads, ref_stores;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
    .mem_write(mem_write), .mem_read(mem_read), .read_data(read_data),
    .ready(ready), .misaligned_err(misaligned_err), .err_addr(err_addr),
    .load_count(load_count), .store_count(store_count)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
    .mem_write(mem_write), .mem_read(mem_read), .read_data(rd4),
    .ready(rdy4), .misaligned_err(err4), .err_addr(ea4),
    .load_count(lc4), .store_count(sc4)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int n, input int maxv);
    return (n > maxv) ? 32'(maxv) : 32'(n);
  endfunction

  function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd2 && (a % 2) != 0) || (sz == 2'd3 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] a);
    int unsigned base;
    logic [7:0]  b;
    logic [15:0] h;
    base = a % BYTES;
    if (sz == 2'd0 || misal(sz, a)) return 32'h0;
    b = ref_mem[base];
    if (sz == 2'd1) return 32'($signed(b));
    h = {ref_mem[base + 1], ref_mem[base]};
    if (sz == 2'd2) return 32'($signed(h));
    return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int unsigned base;
    int n;
    base = a % BYTES;
    n = 1 << (sz - 1);
    for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];
  endtask

  // One RUN-mode access cycle: check the combinational load, then the
  // flags and counters after the edge.
  task automatic cycle(input string tag, input logic [1:0] mr, input logic [1:0] mw,
                       input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    @(negedge clk);
    mem_read = mr; mem_write = mw; addr = a; write_data = wd;
    #1;
    exp_rd = ref_load(mr, a);
    check({tag, ".rd"}, read_data, exp_rd);
    check({tag, ".rd4"}, rd4, exp_rd);
    if (mr != 2'd0 && !misal(mr, a)) ref_loads++;
    if (mw != 2'd0 && !misal(mw, a)) begin
      ref_stores++;
      ref_store(mw, a, wd);
    end
    if (misal(mr, a) || misal(mw, a)) begin
      if (!ref_err) ref_err_addr = a;
      ref_err = 1'b1;
    end
    @(posedge clk);
    #1;
    mem_read = 2'd0; mem_write = 2'd0;
    check({tag, ".err"}, 32'(misaligned_err), 32'(ref_err));
    check({tag, ".eaddr"}, err_addr, ref_err_addr);
    check({tag, ".lc"}, 32'(load_count), sat(ref_loads, 65535));
    check({tag, ".sc"}, 32'(store_count), sat(ref_stores, 65535));
    check({tag, ".lc4"}, 32'(lc4), sat(ref_loads, 15));
    check({tag, ".sc4"}, 32'(sc4), sat(ref_stores, 15));
  endtask

  task automatic reset_dut(input string tag);
    @(negedge clk);
    reset = 1'b1; mem_write = 2'd0; mem_read = 2'd3; addr = 32'h3FC;
    repeat (2) @(posedge clk);
    #1;
    check({tag, ".ready"}, 32'(ready), 32'h0);
    check({tag, ".err"}, 32'(misaligned_err), 32'h0);
    check({tag, ".eaddr"}, err_addr, 32'h0);
    check({tag, ".lc"}, 32'(load_count), 32'h0);
    check({tag, ".sc"}, 32'(store_count), 32'h0);
    check({tag, ".rd"}, read_data, 32'h0);
    ref_err = 1'b0; ref_err_addr = 32'h0; ref_loads = 0; ref_stores = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Counts edges until ready while hammering the port with accesses that
  // must be ignored during the clear sweep.
  task automatic wait_ready(input string tag);
    int edges;
    edges = 0;
    mem_write = 2'd3; mem_read = 2'd3; addr = 32'h0; write_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 128) check({tag, ".clr_rd"}, read_data, 32'h0);
      if (ready) break;
    end
    mem_write = 2'd0; mem_read = 2'd0;
    check({tag, ".edges"}, 32'(edges), 32'd256);
    check({tag, ".rdy4"}, 32'(rdy4), 32'h1);
    check({tag, ".lc_frozen"}, 32'(load_count), 32'h0);
    check({tag, ".sc_frozen"}, 32'(store_count), 32'h0);
    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
  endtask

  initial begin
    logic [1:0]  mr, mw;
    logic [31:0] a;

    reset_dut("rst0");
    wait_ready("clr0");
    cycle("ld3fc", 2'd3, 2'd0, 32'h3FC, 32'h0);
    cycle("ld0",   2'd3, 2'd0, 32'h000, 32'h0);

    cycle("st10", 2'd0, 2'd3, 32'h10, 32'h8000_00FF);
    cycle("lb10", 2'd1, 2'd0, 32'h10, 32'h0);
    cycle("lb13", 2'd1, 2'd0, 32'h13, 32'h0);
    cycle("lh12", 2'd2, 2'd0, 32'h12, 32'h0);

    cycle("st20", 2'd0, 2'd3, 32'h20, 32'h1122_3344);
    cycle("sb21", 2'd0, 2'd1, 32'h21, 32'h0000_00AB);
    cycle("lw20", 2'd3, 2'd0, 32'h20, 32'h0);

    cycle("sw06", 2'd0, 2'd3, 32'h06, 32'hCAFE_F00D);
    cycle("lw04", 2'd3, 2'd0, 32'h04, 32'h0);
    cycle("lh09", 2'd2, 2'd0, 32'h09, 32'h0);

    cycle("st40", 2'd0, 2'd3, 32'h40, 32'h1234_5678);
    cycle("rw40", 2'd3, 2'd3, 32'h40, 32'h5555_5555);
    cycle("lw40", 2'd3, 2'd0, 32'h40, 32'h0);

    cycle("wrapst", 2'd0, 2'd2, 32'h1000_0402, 32'hBEEF_9876);
    cycle("wrapld", 2'd2, 2'd0, 32'h0000_0002, 32'h0);
    cycle("st3f8",  2'd0, 2'd3, 32'h3F8, 32'h7777_7777);

    reset_dut("rst1");
    repeat (100) @(posedge clk);
    reset_dut("rst2");
    wait_ready("clr2");
    cycle("ld3f8", 2'd3, 2'd0, 32'h3F8, 32'h0);

    for (int i = 0; i < 20; i++) cycle("ld20", 2'd3, 2'd0, 32'(i * 4), 32'h0);
    check("lc4_sat", 32'(lc4), 32'h0000_000F);

    for (int i = 0; i < 400; i++) begin
      mr = 2'($urandom_range(0, 3));
      mw = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 63));
      cycle("rnd", mr, mw, a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
